// File: rtl/pc_fetch_unit.sv
// Program-counter and instruction-fetch stage: req/gnt/rvalid fetch, valid/ready issue.
// Optional stall counter output enabled by defining PC_FETCH_STALL_CNT_EN.
module pc_fetch_unit #(
   parameter int ADDR_WIDTH  = 11,
   parameter int INSTR_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [ADDR_WIDTH-1:0]  next_pc_in,
   input  logic                   pc_load,
   input  logic                   halt,
   output logic [ADDR_WIDTH-1:0]  pc_out,
   output logic [ADDR_WIDTH-1:0]  pc_inc_out,
   output logic                   imem_req,
   output logic [ADDR_WIDTH-1:0]  imem_addr,
   input  logic                   imem_gnt,
   input  logic                   imem_rvalid,
   input  logic [INSTR_WIDTH-1:0] imem_rdata,
   output logic                   instr_valid,
   output logic [INSTR_WIDTH-1:0] instr_out,
   input  logic                   instr_ready
`ifdef PC_FETCH_STALL_CNT_EN
   ,
   output logic [15:0]            stall_cnt
`endif
);

   typedef enum logic [1:0] {
      S_REQ    = 2'd0,
      S_WAIT   = 2'd1,
      S_ISSUE  = 2'd2,
      S_HALTED = 2'd3
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);

   state_t                 state_r, state_s;
   logic [ADDR_WIDTH-1:0]  pc_r, pc_s, pc_inc_s;
   logic [INSTR_WIDTH-1:0] instr_r, instr_s;
   logic                   flush_r, flush_s;
   logic                   req_r, valid_r;
   logic                   grant_s;

   // A grant only counts while the request is actually visible on the bus.
   assign grant_s    = req_r & imem_gnt;
   assign pc_inc_s   = pc_r + PC_ONE;
   assign pc_out     = pc_r;
   assign pc_inc_out = pc_inc_s;
   assign imem_addr  = pc_r;
   assign imem_req   = req_r;
   assign instr_valid = valid_r;
   assign instr_out  = instr_r;

   // Next-state, next-PC, capture and flush decisions.
   always_comb begin
      state_s = state_r;
      pc_s    = pc_r;
      instr_s = instr_r;
      flush_s = flush_r;
      case (state_r)
         S_REQ: begin
            if (pc_load) begin
               pc_s = next_pc_in;
            end else begin
               pc_s = pc_r;
            end
            if (grant_s) begin
               state_s = S_WAIT;
               flush_s = pc_load;
            end else begin
               state_s = S_REQ;
            end
         end
         S_WAIT: begin
            if (pc_load) begin
               pc_s = next_pc_in;
            end else begin
               pc_s = pc_r;
            end
            if (imem_rvalid) begin
               if (flush_r || pc_load) begin
                  flush_s = 1'b0;
                  state_s = S_REQ;
               end else begin
                  instr_s = imem_rdata;
                  state_s = S_ISSUE;
               end
            end else if (pc_load) begin
               flush_s = 1'b1;
            end else begin
               state_s = S_WAIT;
            end
         end
         S_ISSUE: begin
            if (instr_ready) begin
               pc_s    = pc_load ? next_pc_in : pc_inc_s;
               state_s = halt ? S_HALTED : S_REQ;
            end else if (pc_load) begin
               pc_s    = next_pc_in;
               state_s = S_REQ;
            end else begin
               state_s = S_ISSUE;
            end
         end
         S_HALTED: begin
            if (pc_load) begin
               pc_s = next_pc_in;
            end else begin
               pc_s = pc_r;
            end
            if (!halt) begin
               state_s = S_REQ;
            end else begin
               state_s = S_HALTED;
            end
         end
         default: begin
            state_s = S_REQ;
         end
      endcase
   end

   // State registers; req/valid are registered from the next state so they stay low in reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_REQ;
         pc_r    <= '0;
         instr_r <= '0;
         flush_r <= 1'b0;
         req_r   <= 1'b0;
         valid_r <= 1'b0;
      end else begin
         state_r <= state_s;
         pc_r    <= pc_s;
         instr_r <= instr_s;
         flush_r <= flush_s;
         req_r   <= (state_s == S_REQ);
         valid_r <= (state_s == S_ISSUE);
      end
   end

`ifdef PC_FETCH_STALL_CNT_EN
   logic [15:0] stall_r;
   logic        stall_ev_s;

   assign stall_ev_s = (valid_r & ~instr_ready) | (req_r & ~imem_gnt);
   assign stall_cnt  = stall_r;

   // Saturating count of decoder back-pressure and ungranted request cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_r <= 16'd0;
      end else if (stall_ev_s && (stall_r != 16'hFFFF)) begin
         stall_r <= stall_r + 16'd1;
      end else begin
         stall_r <= stall_r;
      end
   end
`endif

endmodule
